video_timing_probe: RTL and testbench

- Receive-side counterpart to the video mixer output stage.
- Samples a pixel-qualified VGA-style stream (HS/VS/DE plus pixel enable) and measures line length, active width, frame height and active height.
- Declares lock once the measured timing is stable.
- Used by the OSD/menu firmware to report the video mode, and by downstream scalers to gate processing until timing is valid.

---
 rtl/video_timing_probe.sv | 231 +++++++++++++++++++++++
 tb/tb_video_timing_probe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_probe.sv
// Measures HS/VS/DE timing of a pixel-qualified video stream and declares lock once stable.
// Optional: define VIDEO_PROBE_INTERLACE_EN to accept alternating V_TOTAL and add INTERLACED.
module video_timing_probe #(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             CLK_VIDEO,
  input  logic             RESET_N,
  input  logic             CE_PIXEL,
  input  logic             VGA_HS,
  input  logic             VGA_VS,
  input  logic             VGA_DE,
  output logic [CNT_W-1:0] H_TOTAL,
  output logic [CNT_W-1:0] H_ACTIVE,
  output logic [CNT_W-1:0] V_TOTAL,
  output logic [CNT_W-1:0] V_ACTIVE,
  output logic             UPDATE,
  output logic             LOCKED
`ifdef VIDEO_PROBE_INTERLACE_EN
  ,
  output logic             INTERLACED
`endif
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [3:0]       LockTgt = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  // Input register and previous-sample history
  logic r_ce, r_hs, r_vs, r_de;
  logic r_hs_prev, r_vs_prev;

  // Running counters
  logic [CNT_W-1:0] r_h_cnt, r_de_cnt, r_v_cnt, r_v_act, r_first_act, r_last_h;
  logic             r_act_seen;

  // Candidate set captured at a frame boundary, consumed one cycle later
  logic [CNT_W-1:0] r_cand_ht, r_cand_ha, r_cand_vt, r_cand_va;
  logic             r_frm_evt, r_tmo_evt;

  // Measurement stage
  state_e           r_state, w_state_nxt;
  logic [3:0]       r_match, w_match_nxt, w_match_inc;
  logic [CNT_W-1:0] r_h_total, r_h_active, r_v_total, r_v_active;
  logic             r_update, r_locked;
  logic             w_load, w_clear, w_locked_nxt, w_eq, w_hit;

  logic             w_line, w_frame, w_line_act, w_tmo;
  logic [CNT_W-1:0] w_h_nxt, w_de_nxt, w_v_nxt, w_vact_cl, w_first_cl, w_lasth_cl;

  always_comb begin
    w_line     = r_ce & r_hs & ~r_hs_prev;
    w_frame    = r_ce & r_vs & ~r_vs_prev;
    w_line_act = w_line & (r_de_cnt != '0);
    // "_cl" values include the line being closed on this sample
    w_lasth_cl = w_line ? r_h_cnt : r_last_h;
    w_vact_cl  = (w_line_act && r_v_act != CntMax) ? r_v_act + CntOne : r_v_act;
    w_first_cl = (w_line_act && !r_act_seen) ? r_de_cnt : r_first_act;

    w_h_nxt = r_h_cnt;
    if (w_line) w_h_nxt = CntOne;
    else if (r_ce && r_h_cnt != CntMax) w_h_nxt = r_h_cnt + CntOne;

    w_de_nxt = r_de_cnt;
    if (w_line) w_de_nxt = r_de ? CntOne : '0;
    else if (r_ce && r_de && r_de_cnt != CntMax) w_de_nxt = r_de_cnt + CntOne;

    w_v_nxt = r_v_cnt;
    if (w_frame) w_v_nxt = w_line ? CntOne : '0;
    else if (w_line && r_v_cnt != CntMax) w_v_nxt = r_v_cnt + CntOne;

    w_tmo = r_ce & ((w_h_nxt == CntMax) | (w_v_nxt == CntMax));
  end

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ce        <= 1'b0;
      r_hs        <= 1'b0;
      r_vs        <= 1'b0;
      r_de        <= 1'b0;
      r_hs_prev   <= 1'b0;
      r_vs_prev   <= 1'b0;
      r_h_cnt     <= '0;
      r_de_cnt    <= '0;
      r_v_cnt     <= '0;
      r_v_act     <= '0;
      r_first_act <= '0;
      r_last_h    <= '0;
      r_act_seen  <= 1'b0;
      r_cand_ht   <= '0;
      r_cand_ha   <= '0;
      r_cand_vt   <= '0;
      r_cand_va   <= '0;
      r_frm_evt   <= 1'b0;
      r_tmo_evt   <= 1'b0;
    end else begin
      r_ce <= CE_PIXEL;
      r_hs <= VGA_HS;
      r_vs <= VGA_VS;
      r_de <= VGA_DE;
      if (r_ce) begin
        r_hs_prev   <= r_hs;
        r_vs_prev   <= r_vs;
        r_h_cnt     <= w_h_nxt;
        r_de_cnt    <= w_de_nxt;
        r_v_cnt     <= w_v_nxt;
        r_last_h    <= w_lasth_cl;
        r_v_act     <= w_frame ? '0 : w_vact_cl;
        r_first_act <= w_frame ? '0 : w_first_cl;
        r_act_seen  <= ~w_frame & (r_act_seen | w_line_act);
      end
      r_frm_evt <= w_frame & ~w_tmo;
      r_tmo_evt <= w_tmo;
      if (w_frame) begin
        r_cand_ht <= w_lasth_cl;
        r_cand_ha <= w_first_cl;
        r_cand_vt <= r_v_cnt;
        r_cand_va <= w_vact_cl;
      end
    end
  end

  assign w_eq = (r_cand_ht == r_h_total) && (r_cand_ha == r_h_active) &&
                (r_cand_vt == r_v_total) && (r_cand_va == r_v_active);

`ifdef VIDEO_PROBE_INTERLACE_EN
  logic [CNT_W-1:0] r_vt_prev2;
  logic             r_interlaced;
  logic             w_alt;

  // Alternating field pattern: V_TOTAL toggles by one and repeats every other frame
  assign w_alt = (r_cand_ht == r_h_total) && (r_cand_ha == r_h_active) &&
                 ((r_cand_va == r_v_active) || (r_cand_va == r_v_active + CntOne) ||
                  (r_v_active == r_cand_va + CntOne)) &&
                 ((r_cand_vt == r_v_total + CntOne) || (r_v_total == r_cand_vt + CntOne)) &&
                 (r_cand_vt == r_vt_prev2);
  assign w_hit = w_eq | w_alt;
  assign INTERLACED = r_interlaced;

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      r_vt_prev2   <= '0;
      r_interlaced <= 1'b0;
    end else if (w_clear) begin
      r_vt_prev2   <= '0;
      r_interlaced <= 1'b0;
    end else if (w_load) begin
      r_vt_prev2   <= r_v_total;
      r_interlaced <= w_alt;
    end
  end
`else
  assign w_hit = w_eq;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_match_nxt  = r_match;
    w_locked_nxt = r_locked;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    w_match_inc  = w_hit ? r_match + 4'd1 : 4'd0;
    if (r_tmo_evt) begin
      w_state_nxt  = StSearch;
      w_clear      = 1'b1;
      w_locked_nxt = 1'b0;
      w_match_nxt  = 4'd0;
    end else if (r_frm_evt) begin
      case (r_state)
        StSearch: w_state_nxt = StMeasure;
        StMeasure: begin
          w_load      = 1'b1;
          w_match_nxt = w_match_inc;
          if (!w_hit) w_locked_nxt = 1'b0;
          if (w_match_inc >= LockTgt) begin
            w_locked_nxt = 1'b1;
            w_state_nxt  = StLocked;
          end
        end
        StLocked: begin
          w_load = 1'b1;
          if (!w_hit) begin
            w_locked_nxt = 1'b0;
            w_match_nxt  = 4'd0;
            w_state_nxt  = StMeasure;
          end
        end
        default: w_state_nxt = StSearch;
      endcase
    end
  end

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= StSearch;
      r_match    <= 4'd0;
      r_h_total  <= '0;
      r_h_active <= '0;
      r_v_total  <= '0;
      r_v_active <= '0;
      r_update   <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_match  <= w_match_nxt;
      r_locked <= w_locked_nxt;
      r_update <= w_load;
      if (w_clear) begin
        r_h_total  <= '0;
        r_h_active <= '0;
        r_v_total  <= '0;
        r_v_active <= '0;
      end else if (w_load) begin
        r_h_total  <= r_cand_ht;
        r_h_active <= r_cand_ha;
        r_v_total  <= r_cand_vt;
        r_v_active <= r_cand_va;
      end
    end
  end

  assign H_TOTAL  = r_h_total;
  assign H_ACTIVE = r_h_active;
  assign V_TOTAL  = r_v_total;
  assign V_ACTIVE = r_v_active;
  assign UPDATE   = r_update;
  assign LOCKED   = r_locked;

endmodule

// File: tb/tb_video_timing_probe.sv
// Directed bench for video_timing_probe: a 12-bit probe and an 8-bit probe share one stream.
module tb_video_timing_probe;

  logic clk = 1'b0;
  logic rst_n, ce, hs, vs, de;
  logic [11:0] h_total, h_active, v_total, v_active;
  logic [7:0]  h_total8, h_active8, v_total8, v_active8;
  logic update, locked, update8, locked8;
`ifdef VIDEO_PROBE_INTERLACE_EN
  logic interlaced, interlaced8;
`endif

  int checks = 0;
  int failures = 0;
  int ce_div = 1;
  int cyc = 0;
  int vs_reg_cyc = 0;
  int upd_cyc = 0;
  int n_upd = 0;
  int n_upd8 = 0;

  video_timing_probe #(.CNT_W(12), .LOCK_FRAMES(2)) dut (
    .CLK_VIDEO(clk), .RESET_N(rst_n), .CE_PIXEL(ce), .VGA_HS(hs), .VGA_VS(vs), .VGA_DE(de),
    .H_TOTAL(h_total), .H_ACTIVE(h_active), .V_TOTAL(v_total), .V_ACTIVE(v_active),
    .UPDATE(update), .LOCKED(locked)
`ifdef VIDEO_PROBE_INTERLACE_EN
    , .INTERLACED(interlaced)
`endif
  );

  video_timing_probe #(.CNT_W(8), .LOCK_FRAMES(2)) dut8 (
    .CLK_VIDEO(clk), .RESET_N(rst_n), .CE_PIXEL(ce), .VGA_HS(hs), .VGA_VS(vs), .VGA_DE(de),
    .H_TOTAL(h_total8), .H_ACTIVE(h_active8), .V_TOTAL(v_total8), .V_ACTIVE(v_active8),
    .UPDATE(update8), .LOCKED(locked8)
`ifdef VIDEO_PROBE_INTERLACE_EN
    , .INTERLACED(interlaced8)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (update) begin
      n_upd   <= n_upd + 1;
      upd_cyc <= cyc;
    end
    if (update8) n_upd8 <= n_upd8 + 1;
  end

  // One pixel, held for ce_div cycles with CE asserted on the last of them
  task automatic drive_px(input logic p_hs, input logic p_vs, input logic p_de, input logic mark);
    for (int c = 0; c < ce_div; c++) begin
      ce = (c == ce_div - 1);
      hs = p_hs;
      vs = p_vs;
      de = p_de;
      if (mark && ce) vs_reg_cyc = cyc + 1;
      @(negedge clk);
    end
  endtask

  // HS on px 0-1, VS on line 0, DE on px 4-13 of lines 2-6
  task automatic drive_lines(input int h_tot, input int l_from, input int l_to);
    for (int l = l_from; l <= l_to; l++)
      for (int p = 0; p < h_tot; p++)
        drive_px(p < 2, l == 0, (l >= 2) && (l < 7) && (p >= 4) && (p < 14),
                 (l == 0) && (p == 0));
  endtask

  task automatic run_frame(input int h_tot, input int v_tot);
    drive_lines(h_tot, 0, v_tot - 1);
    #1;
  endtask

  task automatic test_reset();
    if (h_total !== 12'd0) begin failures++; $display("FAIL reset_htotal: got %0d want 0", h_total); end
    checks++;
    if (v_total !== 12'd0) begin failures++; $display("FAIL reset_vtotal: got %0d want 0", v_total); end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %0b want 0", locked); end
    checks++;
    if (update !== 1'b0) begin failures++; $display("FAIL reset_update: got %0b want 0", update); end
    checks++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_lock();
    drive_lines(16, 3, 7);
    #1;
    if (n_upd !== 0) begin failures++; $display("FAIL basic_partial_upd: got %0d want 0", n_upd); end
    checks++;
    run_frame(16, 8);
    if (n_upd !== 0) begin failures++; $display("FAIL basic_search_upd: got %0d want 0", n_upd); end
    checks++;
    run_frame(16, 8);
    if (n_upd !== 1) begin failures++; $display("FAIL basic_first_upd: got %0d want 1", n_upd); end
    checks++;
    if (h_total !== 12'd16) begin failures++; $display("FAIL basic_htotal: got %0d want 16", h_total); end
    checks++;
    if (h_active !== 12'd10) begin failures++; $display("FAIL basic_hactive: got %0d want 10", h_active); end
    checks++;
    if (v_total !== 12'd8) begin failures++; $display("FAIL basic_vtotal: got %0d want 8", v_total); end
    checks++;
    if (v_active !== 12'd5) begin failures++; $display("FAIL basic_vactive: got %0d want 5", v_active); end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL basic_unlocked: got %0b want 0", locked); end
    checks++;
    run_frame(16, 8);
    if (locked !== 1'b1) begin failures++; $display("FAIL basic_locked: got %0b want 1", locked); end
    checks++;
    if (n_upd !== 2) begin failures++; $display("FAIL basic_second_upd: got %0d want 2", n_upd); end
    checks++;
  endtask

  task automatic test_ce_div();
    ce_div = 4;
    run_frame(16, 8);
    run_frame(16, 8);
    if (n_upd !== 4) begin failures++; $display("FAIL ce_upd_count: got %0d want 4", n_upd); end
    checks++;
    if (h_total !== 12'd16) begin failures++; $display("FAIL ce_htotal: got %0d want 16", h_total); end
    checks++;
    if (h_active !== 12'd10) begin failures++; $display("FAIL ce_hactive: got %0d want 10", h_active); end
    checks++;
    if (v_total !== 12'd8) begin failures++; $display("FAIL ce_vtotal: got %0d want 8", v_total); end
    checks++;
    if (v_active !== 12'd5) begin failures++; $display("FAIL ce_vactive: got %0d want 5", v_active); end
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL ce_locked: got %0b want 1", locked); end
    checks++;
    if (upd_cyc - vs_reg_cyc !== 2) begin
      failures++;
      $display("FAIL ce_latency: got %0d cycles want 2", upd_cyc - vs_reg_cyc);
    end
    checks++;
    ce_div = 1;
  endtask

  task automatic test_line_change();
    run_frame(17, 8);
    run_frame(17, 8);
    if (h_total !== 12'd17) begin failures++; $display("FAIL chg_htotal: got %0d want 17", h_total); end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL chg_unlock: got %0b want 0", locked); end
    checks++;
    run_frame(17, 8);
    if (locked !== 1'b1) begin failures++; $display("FAIL chg_relock: got %0b want 1", locked); end
    checks++;
  endtask

  task automatic test_timeout();
    int n0;
    run_frame(16, 8);
    if (locked8 !== 1'b1) begin failures++; $display("FAIL tmo_pre_lock: got %0b want 1", locked8); end
    checks++;
    n0 = n_upd8;
    ce = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    if (n_upd8 !== n0) begin failures++; $display("FAIL tmo_no_upd: got %0d want %0d", n_upd8, n0); end
    checks++;
    if ({h_total8, h_active8, v_total8, v_active8} !== 32'd0) begin
      failures++;
      $display("FAIL tmo_outputs: got %0d/%0d/%0d/%0d want 0/0/0/0",
               h_total8, h_active8, v_total8, v_active8);
    end
    checks++;
    if (locked8 !== 1'b0) begin failures++; $display("FAIL tmo_locked: got %0b want 0", locked8); end
    checks++;
    run_frame(16, 8);
    if (n_upd8 !== n0) begin failures++; $display("FAIL tmo_search_upd: got %0d want %0d", n_upd8, n0); end
    checks++;
    run_frame(16, 8);
    if (n_upd8 !== n0 + 1) begin failures++; $display("FAIL tmo_meas_upd: got %0d want %0d", n_upd8, n0 + 1); end
    checks++;
    if (h_total8 !== 8'd16) begin failures++; $display("FAIL tmo_htotal: got %0d want 16", h_total8); end
    checks++;
    if (locked8 !== 1'b0) begin failures++; $display("FAIL tmo_meas_lock: got %0b want 0", locked8); end
    checks++;
    run_frame(16, 8);
    if (locked8 !== 1'b1) begin failures++; $display("FAIL tmo_relock: got %0b want 1", locked8); end
    checks++;
    if (v_total8 !== 8'd8) begin failures++; $display("FAIL tmo_vtotal: got %0d want 8", v_total8); end
    checks++;
  endtask

  task automatic test_async_reset();
    int n0;
    drive_lines(16, 0, 3);
    if (locked !== 1'b1) begin failures++; $display("FAIL arst_pre_lock: got %0b want 1", locked); end
    checks++;
    #1 rst_n = 1'b0;
    #1;
    if ({h_total, h_active, v_total, v_active} !== 48'd0) begin
      failures++;
      $display("FAIL arst_outputs: got %0d/%0d/%0d/%0d want 0/0/0/0", h_total, h_active, v_total, v_active);
    end
    checks++;
    if (locked !== 1'b0 || locked8 !== 1'b0) begin
      failures++;
      $display("FAIL arst_locked: got %0b/%0b want 0/0", locked, locked8);
    end
    checks++;
    if (h_total8 !== 8'd0) begin failures++; $display("FAIL arst_htotal8: got %0d want 0", h_total8); end
    checks++;
    #1 rst_n = 1'b1;
    n0 = n_upd;
    drive_lines(16, 4, 7);
    run_frame(16, 8);
    if (n_upd !== n0) begin failures++; $display("FAIL arst_partial_upd: got %0d want %0d", n_upd, n0); end
    checks++;
    run_frame(16, 8);
    if (n_upd !== n0 + 1) begin failures++; $display("FAIL arst_first_upd: got %0d want %0d", n_upd, n0 + 1); end
    checks++;
    if (v_active !== 12'd5) begin failures++; $display("FAIL arst_vactive: got %0d want 5", v_active); end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL arst_meas_lock: got %0b want 0", locked); end
    checks++;
  endtask

  task automatic test_interlace();
    int vt_seq[5]  = '{263, 262, 263, 262, 8};
    int exp_vt[5]  = '{8, 263, 262, 263, 262};
    logic exp_lk[5];
    logic alt_lk;
`ifdef VIDEO_PROBE_INTERLACE_EN
    alt_lk = 1'b1;
`else
    alt_lk = 1'b0;
`endif
    exp_lk = '{1'b1, 1'b0, 1'b0, alt_lk, alt_lk};
    for (int f = 0; f < 5; f++) begin
      run_frame(16, vt_seq[f]);
      if (v_total !== 12'(exp_vt[f])) begin
        failures++;
        $display("FAIL ilace_vtotal[%0d]: got %0d want %0d", f, v_total, exp_vt[f]);
      end
      checks++;
      if (locked !== exp_lk[f]) begin
        failures++;
        $display("FAIL ilace_locked[%0d]: got %0b want %0b", f, locked, exp_lk[f]);
      end
      checks++;
`ifdef VIDEO_PROBE_INTERLACE_EN
      if (interlaced !== (f >= 3)) begin
        failures++;
        $display("FAIL ilace_flag[%0d]: got %0b want %0b", f, interlaced, f >= 3);
      end
      checks++;
`endif
    end
    if (h_total !== 12'd16 || v_active !== 12'd5) begin
      failures++;
      $display("FAIL ilace_h_vact: got %0d/%0d want 16/5", h_total, v_active);
    end
    checks++;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    test_basic_lock();
    test_ce_div();
    test_line_change();
    test_timeout();
    test_async_reset();
    test_interlace();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
